// File: rtl/adc_sequencer_if.sv
// ADC control handshake between the sequencer (master) and the analogue ADC (slave).
interface adc_sequencer_if;
   logic        ADC_START;
   logic [4:0]  ADC_CHNUM;
   logic        ADC_CALIBRATE;
   logic        ADC_BUSY;
   logic        ADC_DATAVALID;
   logic [11:0] ADC_RESULT;

   modport master (
      output ADC_START, ADC_CHNUM,
      input  ADC_CALIBRATE, ADC_BUSY, ADC_DATAVALID, ADC_RESULT
   );

   modport slave (
      input  ADC_START, ADC_CHNUM,
      output ADC_CALIBRATE, ADC_BUSY, ADC_DATAVALID, ADC_RESULT
   );
endinterface

// File: rtl/adc_sequencer.sv
// Autonomous ADC channel sweeper: strobes the monitor quad, starts a conversion,
// stores each result in a 32x12 result RAM and streams it out as a sample pulse.
module adc_sequencer #(
   parameter int unsigned STROBE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TIMEOUT_W      = 12
) (
   input  logic                  SYS_CLK,
   input  logic                  SYS_RESET_N,
   input  logic                  enable,
   input  logic [31:0]           channel_mask,
   adc_sequencer_if.master       adc,
   output logic [9:0]            cmstrb,
   output logic [9:0]            tmstrb,
   output logic                  tmstrb_int,
   input  logic [4:0]            rd_addr,
   output logic [11:0]           rd_data,
   output logic                  sample_valid,
   output logic [4:0]            sample_chnum,
   output logic [11:0]           sample_value,
   output logic                  sweep_done,
   output logic                  timeout_err,
   input  logic                  err_clear
);

   typedef enum logic [2:0] {
      CAL_WAIT, SCAN, STROBE, START, WAIT_DV, NEXT, IDLE
   } state_t;

   // Counters run down to zero, so load one less than the cycle count.
   localparam logic [TIMEOUT_W-1:0] STROBE_LOAD  = TIMEOUT_W'(STROBE_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [4:0]           ptr;
   logic [4:0]           chnum;
   logic [TIMEOUT_W-1:0] cnt;
   logic                 start_q;
   logic [11:0]          ram [32];

   logic [63:0]          mask_dbl;
   logic [31:0]          mask_rot;
   logic [4:0]           hit_off;
   logic [4:0]           hit_ch;
   logic [4:0]           top_ch;
   logic                 mask_any;
   logic [20:0]          hit_strb;
   logic                 ram_we;

   // Strobe vector {tmstrb_int, tmstrb[9:0], cmstrb[9:0]} for a channel.
   function automatic logic [20:0] strobe_map(input logic [4:0] ch);
      int unsigned idx;
      int unsigned q;
      int unsigned t;
      strobe_map = '0;
      if (ch == 5'd31) begin
         strobe_map = 21'(1) << 20;
      end else if (ch != 5'd0) begin
         idx = 32'(ch) - 32'd1;
         q   = idx / 3;
         t   = idx % 3;
         if (t == 1)      strobe_map = 21'(1) << q;
         else if (t == 2) strobe_map = 21'(1) << (q + 10);
      end
   endfunction

   // Wrap-around priority search from ptr, plus highest enabled channel.
   always_comb begin
      mask_dbl = {channel_mask, channel_mask};
      mask_rot = 32'(mask_dbl >> ptr);
      hit_off  = '0;
      for (int i = 31; i >= 0; i--) begin
         if (mask_rot[i]) hit_off = 5'(i);
      end
      top_ch = '0;
      for (int i = 0; i < 32; i++) begin
         if (channel_mask[i]) top_ch = 5'(i);
      end
   end

   assign mask_any = |channel_mask;
   assign hit_ch   = ptr + hit_off;
   assign hit_strb = strobe_map(hit_ch);

   assign adc.ADC_START = start_q;
   assign adc.ADC_CHNUM = chnum;

   always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
      if (!SYS_RESET_N) begin
         state        <= CAL_WAIT;
         ptr          <= '0;
         chnum        <= '0;
         cnt          <= '0;
         start_q      <= 1'b0;
         cmstrb       <= '0;
         tmstrb       <= '0;
         tmstrb_int   <= 1'b0;
         sample_valid <= 1'b0;
         sample_chnum <= '0;
         sample_value <= '0;
         sweep_done   <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         start_q      <= 1'b0;
         sample_valid <= 1'b0;
         sweep_done   <= 1'b0;
         // A timeout later in this block overrides the clear.
         if (err_clear) timeout_err <= 1'b0;

         case (state)
            CAL_WAIT: begin
               if (!adc.ADC_CALIBRATE && enable) state <= SCAN;
            end
            SCAN: begin
               if (adc.ADC_CALIBRATE) begin
                  state <= CAL_WAIT;
               end else if (!mask_any) begin
                  state <= IDLE;
               end else begin
                  chnum                       <= hit_ch;
                  cnt                         <= STROBE_LOAD;
                  {tmstrb_int, tmstrb, cmstrb} <= hit_strb;
                  state                       <= (hit_strb == '0) ? START : STROBE;
               end
            end
            STROBE: begin
               // Last strobe cycle issues the start directly unless the ADC is busy.
               if (cnt != '0) begin
                  cnt <= cnt - TIMEOUT_W'(1);
               end else if (adc.ADC_BUSY) begin
                  state <= START;
               end else begin
                  start_q <= 1'b1;
                  cnt     <= TIMEOUT_LOAD;
                  state   <= WAIT_DV;
               end
            end
            START: begin
               if (!adc.ADC_BUSY) begin
                  start_q <= 1'b1;
                  cnt     <= TIMEOUT_LOAD;
                  state   <= WAIT_DV;
               end
            end
            WAIT_DV: begin
               if (adc.ADC_DATAVALID) begin
                  sample_valid                 <= 1'b1;
                  sample_chnum                 <= chnum;
                  sample_value                 <= adc.ADC_RESULT;
                  {tmstrb_int, tmstrb, cmstrb} <= '0;
                  state                        <= NEXT;
               end else if (cnt == '0) begin
                  timeout_err                  <= 1'b1;
                  {tmstrb_int, tmstrb, cmstrb} <= '0;
                  state                        <= NEXT;
               end else begin
                  cnt <= cnt - TIMEOUT_W'(1);
               end
            end
            NEXT: begin
               if (mask_any && chnum == top_ch) sweep_done <= 1'b1;
               ptr   <= chnum + 5'd1;
               state <= enable ? SCAN : IDLE;
            end
            IDLE: begin
               {tmstrb_int, tmstrb, cmstrb} <= '0;
               if (adc.ADC_CALIBRATE)          state <= CAL_WAIT;
               else if (enable && mask_any)    state <= SCAN;
            end
            default: state <= CAL_WAIT;
         endcase
      end
   end

   assign ram_we = (state == WAIT_DV) && adc.ADC_DATAVALID;

   // Result RAM holds no reset; read-during-write returns the old word.
   always_ff @(posedge SYS_CLK) begin
      if (ram_we) ram[chnum] <= adc.ADC_RESULT;
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
      if (!SYS_RESET_N) rd_data <= '0;
      else              rd_data <= ram[rd_addr];
   end

endmodule
